alu_sweep_ctrl: RTL
===================

ALU_SWEEP_CTRL -- requirements
Module: alu_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles the controller SHALL hold each operand/op set on the ALU before sampling; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous sweep cancel.
REQ-006 a_in  input  2  operand A, latched on start acceptance.
REQ-007 b_in  input  2  operand B, latched on start acceptance.
REQ-008 alu_a  output  2  operand A driven to the external ALU.
REQ-009 alu_b  output  2  operand B driven to the external ALU.
REQ-010 alu_op  output  3  opcode driven to the external ALU.
REQ-011 alu_result  input  2  combinational ALU result.
REQ-012 busy  output  1  high in DRIVE or CAPTURE.
REQ-013 results  output  16  packed results; slot k (result of op k) at bits [2k+1:2k].
REQ-014 results_valid  output  1  results complete and stable.
REQ-015 results_ready  input  1  consumer accepts results.
REQ-016 sweep_count  output  8  completed sweeps, saturating at 255.

Function
REQ-017 States SHALL be IDLE, DRIVE, CAPTURE, DONE.
REQ-018 IDLE with start=1: latch a_in/b_in into alu_a/alu_b, set alu_op=0, clear results to 0, settle counter=0, go DRIVE.
REQ-019 DRIVE SHALL last exactly SETTLE cycles with alu_a, alu_b, alu_op stable, then go CAPTURE.
REQ-020 On the edge leaving CAPTURE, alu_result SHALL be written to results slot alu_op; other slots unchanged.
REQ-021 Leaving CAPTURE with alu_op<7: alu_op increments by 1, go DRIVE; with alu_op=7: alu_op stays 7, go DONE.
REQ-022 Latency: results_valid SHALL rise exactly 8*(SETTLE+1) cycles after the edge that accepted start.
REQ-023 DONE: results_valid=1, results held constant; on edge with results_ready=1, go IDLE, results_valid=0, sweep_count increments (saturates at 255, no wrap).
REQ-024 results_valid SHALL be 0 in every state other than DONE; results_ready outside DONE SHALL be ignored.
REQ-025 start SHALL be ignored in DRIVE, CAPTURE and DONE; no queuing.
REQ-026 abort=1 in DRIVE or CAPTURE: go IDLE next edge, results cleared to 0, alu_op=0, sweep_count unchanged.
REQ-027 abort=1 in IDLE or DONE: no effect; abort has priority over start and capture in the same cycle.
REQ-028 start and results_ready both high in DONE: handshake completes to IDLE; start not accepted until next IDLE cycle.
REQ-029 In IDLE, alu_a/alu_b/alu_op SHALL retain last driven values (no toggling).

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, alu_a=0, alu_b=0, alu_op=0, busy=0, results=0, results_valid=0, sweep_count=0, regardless of state, including mid-sweep.
REQ-031 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-032 SETTLE=1, ALU stub result=(alu_a+alu_op) mod 4, start with a_in=2,b_in=1 -> alu_op steps 0..7 every 2 cycles, results_valid at cycle 16, results=0x4E4E, sweep_count=1 after ready.
REQ-033 SETTLE=3, same stub and a_in=2 -> results_valid at cycle 32, results=0x4E4E; alu_op each value held 4 cycles.
REQ-034 abort pulsed while alu_op=4 -> next cycle IDLE, busy=0, results=0, results_valid never rises, sweep_count unchanged.
REQ-035 rst_n pulled low while alu_op=5 -> all outputs zero immediately; subsequent start completes normally with results=0x4E4E.
REQ-036 results_ready held low 10 cycles in DONE -> results and results_valid stable throughout; start pulses ignored; 256 completed sweeps -> sweep_count=255.

Source files
------------

// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: steps an external ALU through all eight opcodes
// for one latched operand pair and collects the packed results.
module alu_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  a_in,
  input  logic [1:0]  b_in,
  output logic [1:0]  alu_a,
  output logic [1:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [1:0]  alu_result,
  output logic        busy,
  output logic [15:0] results,
  output logic        results_valid,
  input  logic        results_ready,
  output logic [7:0]  sweep_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;

  // Sweep sequencer; busy/results_valid are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      busy          <= 1'b0;
      results       <= '0;
      results_valid <= 1'b0;
      sweep_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // abort in the same cycle wins over start
          if (start && !abort) begin
            alu_a   <= a_in;
            alu_b   <= b_in;
            alu_op  <= '0;
            results <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            results <= '0;
            alu_op  <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            results <= '0;
            alu_op  <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            results[{alu_op, 1'b0} +: 2] <= alu_result;
            cnt <= '0;
            if (alu_op == 3'd7) begin
              busy          <= 1'b0;
              results_valid <= 1'b1;
              state         <= DONE;
            end else begin
              alu_op <= alu_op + 3'd1;
              state  <= DRIVE;
            end
          end
        end
        DONE: begin
          if (results_ready) begin
            results_valid <= 1'b0;
            state         <= IDLE;
            if (sweep_count != 8'hFF)
              sweep_count <= sweep_count + 8'd1;
          end
        end
        default: begin
          busy          <= 1'b0;
          results_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
